tiny_cpu_ctrl: RTL and testbench
================================

# tiny_cpu_ctrl

Multicycle control unit for the tiny RISC CPU, sitting directly upstream of the CPU datapath. It consumes the 2-bit opcode and drives every datapath load, increment and bus-enable strobe. It also drives the memory read and write strobes and paces each access on a memory-ready handshake. It sequences fetch → decode → execute for the four instructions:

- 00 LDA: load the accumulator from memory.
- 01 STA: store the accumulator to memory.
- 10 ADD: add a 6-bit immediate to the accumulator.
- 11 JMP: jump.

## Interface
Parameters:
- WAIT_MAX, 15: maximum number of cycles a memory access may wait for mem_rdy before a bus fault (1..255).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- op_code  in  2  instruction opcode from the datapath (IR[7:6]).
- mem_rdy  in  1  memory completes the current access this cycle.
- halt_req  in  1  stop at the next instruction boundary.
- pc_on_adr, ir_on_adr  out  1 each  address-bus source select.
- data_on_dbus, alu_on_dbus  out  1 each  internal-bus source select.
- dbus_on_data  out  1  drive the external data bus.
- ld_ir, ld_ac, ld_pc, inc_pc, clr_pc  out  1 each  register strobes.
- pass, add  out  1 each  ALU function select.
- read_mem, write_mem  out  1 each  memory strobes.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- halted  out  1  controller is parked in HALT.
- bus_err  out  1  sticky flag: memory timeout fault.

## Operation
- States: RESET, FETCH, DECODE, RD, WR, ADD, JMP, HALT, FAULT. Binary encoded, registered state. Outputs are decoded from the state and mem_rdy.
- **RESET:** clr_pc=1, all other outputs 0. Next state FETCH.
- **FETCH:** pc_on_adr=1, read_mem=1, data_on_dbus=1.
  - ld_ir and inc_pc are asserted only in the cycle mem_rdy=1, then next state is DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** no strobes. Next state by op_code: 00→RD, 01→WR, 10→ADD, 11→JMP.
- **RD:** ir_on_adr=1, read_mem=1, data_on_dbus=1. ld_ac only in the cycle mem_rdy=1, then retire.
- **WR:** ir_on_adr=1, write_mem=1, pass=1, alu_on_dbus=1, dbus_on_data=1. Held until mem_rdy=1, then retire.
- **ADD:** add=1, alu_on_dbus=1, ld_ac=1 for one cycle, then retire.
- **JMP:** ld_pc=1 for one cycle, then retire.
- **Retire:**
  - instr_done=1 during the retiring cycle.
  - Next state is HALT if halt_req=1 in that cycle, else FETCH.
- **HALT:** halted=1, all strobes 0. Return to FETCH in the cycle after halt_req is sampled 0.
- **Wait counter:**
  - 8-bit counter, cleared on entry to FETCH, RD and WR, and on every cycle mem_rdy=1.
  - Increments each cycle in FETCH, RD or WR with mem_rdy=0.
  - When it equals WAIT_MAX with mem_rdy still 0, next state is FAULT.
- **FAULT:** bus_err=1, all strobes 0. Left only by reset.
- **Exclusivity invariants,** which hold in every cycle:
  - pc_on_adr & ir_on_adr = 0.
  - data_on_dbus & alu_on_dbus = 0.
  - read_mem & write_mem = 0.
  - pass & add = 0.
  - dbus_on_data=1 implies data_on_dbus=0.

## Timing
- Reset:
  - While rst_n=0 at a clock edge, the state becomes RESET and the counter is cleared.
  - In RESET, clr_pc=1 and every other output is 0, including bus_err, halted and instr_done.
  - The first edge with rst_n=1 moves the state to FETCH.
- Reset mid-access (any state) aborts the access; strobes drop in the cycle after the reset edge.
- Instruction latency, in cycles, with zero-wait memory (mem_rdy tied 1):
  - LDA 3 (FETCH, DECODE, RD).
  - STA 3.
  - ADD 3.
  - JMP 3.
- Each cycle of mem_rdy=0 in FETCH, RD or WR adds exactly one cycle.
- A mem_rdy pulse outside FETCH, RD or WR is ignored.
- halt_req sampled only in the retiring cycle; assertion at any other time has no effect until the next retire.
- Fault timing: an access whose mem_rdy never rises enters FAULT on the edge after the WAIT_MAX-th consecutive wait cycle. Total FETCH/RD/WR residency before FAULT is WAIT_MAX+1 cycles.
- mem_rdy=1 in the same cycle the counter reaches WAIT_MAX completes the access normally, with no fault.

## Test plan
- Reset, then zero-wait program LDA, ADD, STA, JMP:
  - clr_pc=1 one cycle after release.
  - Each instruction takes 3 cycles and instr_done pulses 4 times in 12 cycles.
  - Each instruction's strobe set matches its Operation entry.
- FETCH with mem_rdy low 3 cycles then high:
  - FETCH lasts 4 cycles.
  - ld_ir and inc_pc are high only in the 4th cycle.
  - inc_pc count is exactly 1.
- STA with mem_rdy never asserted, WAIT_MAX=15:
  - Enters FAULT after 16 WR cycles, bus_err=1 and all strobes 0.
  - Stays there 20+ cycles, until rst_n=0.
  - mem_rdy=1 on the 16th WR cycle instead gives a normal retire with bus_err=0.
- halt_req=1 during an ADD retire:
  - halted=1 from the next cycle.
  - Deassert halt_req; FETCH resumes one cycle later with no lost or duplicated inc_pc.
- rst_n=0 in the 2nd cycle of an RD wait:
  - read_mem and ir_on_adr are 0 after that edge and clr_pc=1.
  - ld_ac never pulses.
  - Clean FETCH follows release.
- Randomized mem_rdy over 1000 cycles: exclusivity invariants are never violated.

Source files
------------

// File: rtl/tiny_cpu_ctrl.sv
// Multicycle control unit for the tiny RISC CPU: fetch/decode/execute sequencing
// with a memory-ready handshake, a wait-timeout bus fault and a halt request.
module tiny_cpu_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] op_code,
  input  logic       mem_rdy,
  input  logic       halt_req,
  output logic       pc_on_adr,
  output logic       ir_on_adr,
  output logic       data_on_dbus,
  output logic       alu_on_dbus,
  output logic       dbus_on_data,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       clr_pc,
  output logic       pass,
  output logic       add,
  output logic       read_mem,
  output logic       write_mem,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_RD, S_WR, S_ADD, S_JMP, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  state_t     retire_st;

  assign retire_st = halt_req ? S_HALT : S_FETCH;

  // Next state; the wait counter only survives while an access keeps waiting,
  // so every entry into FETCH/RD/WR and every ready cycle starts it at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_rdy)                state_d = S_DECODE;
        else if (cnt_q == WAIT_LIM) state_d = S_FAULT;
        else                        cnt_d   = cnt_q + 8'd1;
      end
      S_DECODE: begin
        case (op_code)
          2'b00:   state_d = S_RD;
          2'b01:   state_d = S_WR;
          2'b10:   state_d = S_ADD;
          default: state_d = S_JMP;
        endcase
      end
      S_RD, S_WR: begin
        if (mem_rdy)                state_d = retire_st;
        else if (cnt_q == WAIT_LIM) state_d = S_FAULT;
        else                        cnt_d   = cnt_q + 8'd1;
      end
      S_ADD, S_JMP: state_d = retire_st;
      S_HALT:       if (!halt_req) state_d = S_FETCH;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe decode from the current state and the memory handshake.
  always_comb begin
    pc_on_adr    = 1'b0;
    ir_on_adr    = 1'b0;
    data_on_dbus = 1'b0;
    alu_on_dbus  = 1'b0;
    dbus_on_data = 1'b0;
    ld_ir        = 1'b0;
    ld_ac        = 1'b0;
    ld_pc        = 1'b0;
    inc_pc       = 1'b0;
    clr_pc       = 1'b0;
    pass         = 1'b0;
    add          = 1'b0;
    read_mem     = 1'b0;
    write_mem    = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    bus_err      = 1'b0;
    case (state_q)
      S_RESET: clr_pc = 1'b1;
      S_FETCH: begin
        pc_on_adr    = 1'b1;
        read_mem     = 1'b1;
        data_on_dbus = 1'b1;
        ld_ir        = mem_rdy;
        inc_pc       = mem_rdy;
      end
      S_RD: begin
        ir_on_adr    = 1'b1;
        read_mem     = 1'b1;
        data_on_dbus = 1'b1;
        ld_ac        = mem_rdy;
        instr_done   = mem_rdy;
      end
      S_WR: begin
        ir_on_adr    = 1'b1;
        write_mem    = 1'b1;
        pass         = 1'b1;
        alu_on_dbus  = 1'b1;
        dbus_on_data = 1'b1;
        instr_done   = mem_rdy;
      end
      S_ADD: begin
        add         = 1'b1;
        alu_on_dbus = 1'b1;
        ld_ac       = 1'b1;
        instr_done  = 1'b1;
      end
      S_JMP: begin
        ld_pc      = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  halted  = 1'b1;
      S_FAULT: bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tiny_cpu_ctrl.sv
// Bench for tiny_cpu_ctrl: directed program/wait/fault/halt/reset scenarios plus
// randomized handshakes, all checked every cycle against an instruction-level model.
module tb_tiny_cpu_ctrl;
  localparam int WAIT_MAX = 15;

  logic clk, rst_n, mem_rdy, halt_req;
  logic [1:0] op_code;
  logic pc_on_adr, ir_on_adr, data_on_dbus, alu_on_dbus, dbus_on_data;
  logic ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass, add, read_mem, write_mem;
  logic instr_done, halted, bus_err;

  tiny_cpu_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .mem_rdy(mem_rdy), .halt_req(halt_req),
    .pc_on_adr(pc_on_adr), .ir_on_adr(ir_on_adr), .data_on_dbus(data_on_dbus),
    .alu_on_dbus(alu_on_dbus), .dbus_on_data(dbus_on_data), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_pc(clr_pc), .pass(pass), .add(add),
    .read_mem(read_mem), .write_mem(write_mem), .instr_done(instr_done),
    .halted(halted), .bus_err(bus_err)
  );

  localparam logic [16:0] B_PCADR = 17'h10000, B_IRADR = 17'h08000, B_DDB  = 17'h04000,
                          B_ADB   = 17'h02000, B_DBD   = 17'h01000, B_LDIR = 17'h00800,
                          B_LDAC  = 17'h00400, B_LDPC  = 17'h00200, B_INC  = 17'h00100,
                          B_CLR   = 17'h00080, B_PASS  = 17'h00040, B_ADD  = 17'h00020,
                          B_RD    = 17'h00010, B_WR    = 17'h00008, B_DONE = 17'h00004,
                          B_HALT  = 17'h00002, B_BERR  = 17'h00001;
  localparam logic [16:0] FETCH_W = B_PCADR | B_RD | B_DDB;
  localparam logic [16:0] FETCH_R = FETCH_W | B_LDIR | B_INC;
  localparam logic [16:0] RD_W    = B_IRADR | B_RD | B_DDB;
  localparam logic [16:0] WR_W    = B_IRADR | B_WR | B_PASS | B_ADB | B_DBD;

  logic [16:0] dut_v;
  assign dut_v = {pc_on_adr, ir_on_adr, data_on_dbus, alu_on_dbus, dbus_on_data, ld_ir,
                  ld_ac, ld_pc, inc_pc, clr_pc, pass, add, read_mem, write_mem,
                  instr_done, halted, bus_err};

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction-level model: in reset / faulted / halted, or at step 0 (fetch),
  // 1 (decode) or 2 (execute) of the current instruction, with its latched opcode.
  logic       m_valid = 1'b0;
  logic       m_rst = 1'b0, m_halt = 1'b0, m_fault = 1'b0;
  int         m_step = 0;
  int         m_waits = 0;
  logic [1:0] m_op = 2'd0;
  logic       m_access;
  assign m_access = (m_step == 0) || (m_step == 2 && m_op[1] == 1'b0);

  function automatic logic [16:0] model_out(input logic rdy);
    if (m_rst)   return B_CLR;
    if (m_fault) return B_BERR;
    if (m_halt)  return B_HALT;
    if (m_step == 0) return rdy ? FETCH_R : FETCH_W;
    if (m_step == 1) return 17'h0;
    case (m_op)
      2'd0:    return rdy ? (RD_W | B_LDAC | B_DONE) : RD_W;
      2'd1:    return rdy ? (WR_W | B_DONE) : WR_W;
      2'd2:    return B_ADD | B_ADB | B_LDAC | B_DONE;
      default: return B_LDPC | B_DONE;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b1; m_rst <= 1'b1; m_halt <= 1'b0; m_fault <= 1'b0;
      m_step <= 0; m_waits <= 0;
    end else if (m_valid) begin
      if (m_rst) begin
        m_rst <= 1'b0; m_step <= 0; m_waits <= 0;
      end else if (m_fault) begin
        m_fault <= 1'b1;
      end else if (m_halt) begin
        if (!halt_req) begin m_halt <= 1'b0; m_step <= 0; m_waits <= 0; end
      end else if (m_step == 1) begin
        m_op <= op_code; m_step <= 2; m_waits <= 0;
      end else if (m_access && !mem_rdy) begin
        if (m_waits == WAIT_MAX) m_fault <= 1'b1;
        else m_waits <= m_waits + 1;
      end else if (m_step == 0) begin
        m_step <= 1; m_waits <= 0;
      end else begin
        m_step <= 0; m_waits <= 0; m_halt <= halt_req;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle_model", dut_v, model_out(mem_rdy));
      check("exclusivity",
            {12'h0, pc_on_adr & ir_on_adr, data_on_dbus & alu_on_dbus,
             read_mem & write_mem, pass & add, dbus_on_data & data_on_dbus}, 17'h0);
    end
  end

  logic [16:0] snap;
  task automatic cyc();
    @(negedge clk);
    snap = dut_v;
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  ops[4];
  logic [16:0] exec_lit[4];
  int done_cnt, inc_cnt, ldac_cnt, bias;

  initial begin
    ops      = '{2'd0, 2'd2, 2'd1, 2'd3};
    exec_lit = '{RD_W | B_LDAC | B_DONE, WR_W | B_DONE,
                 B_ADD | B_ADB | B_LDAC | B_DONE, B_LDPC | B_DONE};
    rst_n = 1'b0; mem_rdy = 1'b1; halt_req = 1'b0; op_code = 2'd0;
    cyc(); cyc();
    check("reset_state", snap, B_CLR);
    rst_n = 1'b1;
    cyc();
    check("release_clr_pc", snap, B_CLR);

    // zero-wait LDA, ADD, STA, JMP
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      op_code = ops[i];
      cyc(); check("prog_fetch", snap, FETCH_R);
      if ((snap & B_DONE) != 0) done_cnt++;
      cyc(); check("prog_decode", snap, 17'h0);
      if ((snap & B_DONE) != 0) done_cnt++;
      cyc(); check("prog_exec", snap, exec_lit[ops[i]]);
      if ((snap & B_DONE) != 0) done_cnt++;
    end
    check("done_in_12", 17'(done_cnt), 17'd4);

    // fetch with three wait cycles
    inc_cnt = 0;
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); check("fetch_wait", snap, FETCH_W);
      if ((snap & B_INC) != 0) inc_cnt++;
    end
    mem_rdy = 1'b1;
    cyc(); check("fetch_4th", snap, FETCH_R);
    if ((snap & B_INC) != 0) inc_cnt++;
    check("fetch_inc_once", 17'(inc_cnt), 17'd1);

    // STA that never completes
    op_code = 2'd1; mem_rdy = 1'b0;
    cyc(); check("sta_decode", snap, 17'h0);
    for (int k = 0; k < 16; k++) begin
      cyc(); check("wr_wait", snap, WR_W);
    end
    for (int k = 0; k < 22; k++) begin
      mem_rdy = 1'($urandom_range(0, 1));
      cyc(); check("fault_hold", snap, B_BERR);
    end
    rst_n = 1'b0;
    cyc(); check("fault_until_reset", snap, B_BERR);
    rst_n = 1'b1;
    cyc(); check("fault_reset", snap, B_CLR);

    // STA completing on its last allowed wait cycle
    mem_rdy = 1'b1;
    cyc(); check("sta2_fetch", snap, FETCH_R);
    cyc();
    mem_rdy = 1'b0;
    for (int k = 0; k < 15; k++) cyc();
    mem_rdy = 1'b1;
    cyc(); check("wr_16th_retire", snap, WR_W | B_DONE);

    // ADD retiring with halt requested
    inc_cnt = 0;
    cyc(); check("halt_fetch", snap, FETCH_R);
    op_code = 2'd2;
    cyc();
    halt_req = 1'b1;
    cyc(); check("halt_add_retire", snap, B_ADD | B_ADB | B_LDAC | B_DONE);
    for (int k = 0; k < 3; k++) begin
      cyc(); check("halted", snap, B_HALT);
      if ((snap & B_INC) != 0) inc_cnt++;
    end
    halt_req = 1'b0;
    cyc(); check("halt_release", snap, B_HALT);
    cyc(); check("halt_resume", snap, FETCH_R);
    if ((snap & B_INC) != 0) inc_cnt++;
    check("halt_inc_once", 17'(inc_cnt), 17'd1);

    // reset in the 2nd cycle of an RD wait
    ldac_cnt = 0;
    op_code = 2'd0;
    cyc();
    mem_rdy = 1'b0;
    cyc(); check("rd_wait1", snap, RD_W);
    if ((snap & B_LDAC) != 0) ldac_cnt++;
    rst_n = 1'b0;
    cyc(); check("rd_wait2", snap, RD_W);
    if ((snap & B_LDAC) != 0) ldac_cnt++;
    rst_n = 1'b1;
    cyc(); check("rd_abort", snap, B_CLR);
    if ((snap & B_LDAC) != 0) ldac_cnt++;
    mem_rdy = 1'b1;
    cyc(); check("rd_clean_fetch", snap, FETCH_R);
    check("rd_no_ld_ac", 17'(ldac_cnt), 17'd0);

    // randomized handshakes, opcodes, halts and occasional resets
    bias = 50;
    for (int n = 0; n < 1000; n++) begin
      if (n % 100 == 0) bias = $urandom_range(5, 95);
      rst_n    = ($urandom_range(0, 199) != 0);
      mem_rdy  = ($urandom_range(0, 99) < bias);
      halt_req = ($urandom_range(0, 7) == 0);
      op_code  = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
